// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and helpers for the fetch unit and its buffer.
package fetch_unit_pkg;
   localparam logic [6:0] RV_OPC_JAL = 7'b1101111;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred_taken;
   } fetch_entry_t;
   function automatic logic [31:0] j_imm(input logic [31:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch buffer with flush; caller gates push/pop.
module fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  T                           din,
   output T                           dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   T mem [DEPTH];
   logic [PW-1:0] head, tail;
   assign dout = mem[head];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      end
   always_ff @(posedge clk)
      if (push && !flush) mem[tail] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation feeding a fetch buffer toward decode.
// Define FETCH_JAL_PREDICT_EN to enable static JAL-taken prediction.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] icache_addr,
   input  logic [31:0] icache_instr,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_instr,
   output logic [31:0] fetch_pc,
   output logic        fetch_pred_taken,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   logic [31:0]   pc, next_pc;
   logic          pred, push, pop;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   logic          unused_pred;
`ifdef FETCH_JAL_PREDICT_EN
   assign pred             = icache_instr[6:0] == RV_OPC_JAL;
   assign next_pc          = pred ? pc + j_imm(icache_instr) : pc + 32'd4;
   assign fetch_pred_taken = head.pred_taken;
`else
   assign pred             = 1'b0;
   assign next_pc          = pc + 32'd4;
   assign fetch_pred_taken = 1'b0;
`endif
   assign unused_pred = head.pred_taken;
   assign icache_addr = pc;
   assign fetch_valid = count != '0;
   assign fetch_pc    = head.pc;
   assign fetch_instr = head.instr;
   // Redirect wins over both ends of the buffer.
   assign pop  = fetch_valid && fetch_ready && !redirect_valid;
   assign push = !redirect_valid && (count < CW'(BUF_DEPTH) || pop);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pc <= RESET_PC & ~32'd3;
      else if (redirect_valid) pc <= redirect_pc & ~32'd3;
      else if (push) pc <= next_pc;
   fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   ('{pc: pc, instr: icache_instr, pred_taken: pred}),
      .dout  (head),
      .count (count)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue model.
module tb_fetch_unit;
   localparam logic [31:0] RPC   = 32'h100;
   localparam int          DEPTH = 4;
`ifdef FETCH_JAL_PREDICT_EN
   localparam bit JAL_EN = 1'b1;
`else
   localparam bit JAL_EN = 1'b0;
`endif
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred;
   } ent_t;

   logic        clk = 0, rst_n = 0;
   logic [31:0] icache_addr, icache_instr, fetch_instr, fetch_pc, redirect_pc = 0;
   logic        fetch_valid, fetch_ready = 0, fetch_pred_taken, redirect_valid = 0;
   logic [31:0] imem [256];
   ent_t        q[$];
   logic [31:0] m_pc;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;
   assign icache_instr = imem[icache_addr[9:2]];

   fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .icache_addr(icache_addr), .icache_instr(icache_instr),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
      .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   // Reference: one clock edge of the buffer/PC behaviour, from the current inputs.
   task automatic model_edge();
      ent_t  e;
      bit    do_pop, do_push;
      logic [20:0] imm;
      if (redirect_valid) begin
         q.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
         return;
      end
      do_pop  = q.size() > 0 && fetch_ready;
      do_push = q.size() < DEPTH || do_pop;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         e.pc    = m_pc;
         e.instr = imem[m_pc[9:2]];
         e.pred  = JAL_EN && e.instr[6:0] == 7'b1101111;
         imm     = {e.instr[31], e.instr[19:12], e.instr[20], e.instr[30:21], 1'b0};
         q.push_back(e);
         m_pc    = e.pred ? m_pc + 32'($signed(imm)) : m_pc + 32'd4;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #2;
      q.delete();
      m_pc  = RPC;
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      fetch_ready = 1;
      #1;
      n_cmp++;
      if (icache_addr !== RPC || fetch_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: addr=%h valid=%b required addr=%h valid=0", icache_addr, fetch_valid, RPC);
      end
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         cycle();
         n_cmp++;
         if (icache_addr !== RPC + 32'(4 * i) || fetch_valid !== 1'b1 || fetch_pc !== RPC + 32'(4 * (i - 1))) begin
            n_bad++;
            $display("FAIL first_pushes[%0d]: addr=%h valid=%b pc=%h required addr=%h valid=1 pc=%h",
                     i, icache_addr, fetch_valid, fetch_pc, RPC + 32'(4 * i), RPC + 32'(4 * (i - 1)));
         end
      end
   endtask

   task automatic test_stall();
      fetch_ready = 0;
      do_reset();
      repeat (6) cycle();
      n_cmp++;
      if (icache_addr !== 32'h110 || fetch_pc !== 32'h100 || fetch_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL stall: addr=%h pc=%h valid=%b required addr=110 pc=100 valid=1", icache_addr, fetch_pc, fetch_valid);
      end
      fetch_ready = 1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (fetch_pc !== 32'h100 + 32'(4 * i)) begin
            n_bad++;
            $display("FAIL drain[%0d]: pc=%h required %h", i, fetch_pc, 32'h100 + 32'(4 * i));
         end
         cycle();
         if (i == 0) begin
            n_cmp++;
            if (icache_addr !== 32'h114 || fetch_pc !== 32'h104) begin
               n_bad++;
               $display("FAIL full_push_pop: addr=%h pc=%h required addr=114 pc=104", icache_addr, fetch_pc);
            end
         end
      end
   endtask

   task automatic test_redirect();
      fetch_ready = 0;
      do_reset();
      repeat (3) cycle();
      fetch_ready = 1;
      redirect_valid = 1;
      redirect_pc = 32'h203;
      cycle();
      redirect_valid = 0;
      n_cmp++;
      if (fetch_valid !== 1'b0 || icache_addr !== 32'h200) begin
         n_bad++;
         $display("FAIL redirect: valid=%b addr=%h required valid=0 addr=200", fetch_valid, icache_addr);
      end
      cycle();
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h200) begin
         n_bad++;
         $display("FAIL redirect_first: valid=%b pc=%h required valid=1 pc=200", fetch_valid, fetch_pc);
      end
   endtask

   task automatic test_jal();
      logic [31:0] exp_addr;
      exp_addr = JAL_EN ? 32'h48 : 32'h44;
      fetch_ready = 1;
      redirect_valid = 1;
      redirect_pc = 32'h40;
      cycle();
      redirect_valid = 0;
      cycle();
      n_cmp++;
      if (icache_addr !== exp_addr || fetch_pc !== 32'h40 || fetch_pred_taken !== JAL_EN || fetch_instr !== 32'h0080006F) begin
         n_bad++;
         $display("FAIL jal: addr=%h pc=%h pred=%b instr=%h required addr=%h pc=40 pred=%b instr=0080006f",
                  icache_addr, fetch_pc, fetch_pred_taken, fetch_instr, exp_addr, JAL_EN);
      end
   endtask

   task automatic test_async_reset();
      fetch_ready = 0;
      do_reset();
      repeat (2) cycle();
      #2;
      rst_n = 0;
      #1;
      n_cmp++;
      if (fetch_valid !== 1'b0 || icache_addr !== RPC) begin
         n_bad++;
         $display("FAIL async_reset: valid=%b addr=%h required valid=0 addr=%h", fetch_valid, icache_addr, RPC);
      end
      do_reset();
      cycle();
      n_cmp++;
      if (fetch_pc !== RPC || fetch_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL post_reset_push: pc=%h valid=%b required pc=%h valid=1", fetch_pc, fetch_valid, RPC);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         fetch_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = $urandom;
         cycle();
         redirect_valid = 0;
         n_cmp++;
         if (icache_addr !== m_pc || fetch_valid !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL rand_ctl[%0d]: addr=%h valid=%b required addr=%h valid=%b",
                     i, icache_addr, fetch_valid, m_pc, q.size() != 0);
         end else if (q.size() != 0) begin
            n_cmp++;
            if (fetch_pc !== q[0].pc || fetch_instr !== q[0].instr || fetch_pred_taken !== q[0].pred) begin
               n_bad++;
               $display("FAIL rand_head[%0d]: pc=%h instr=%h pred=%b required pc=%h instr=%h pred=%b",
                        i, fetch_pc, fetch_instr, fetch_pred_taken, q[0].pc, q[0].instr, q[0].pred);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         imem[i] = $urandom;
         if ($urandom_range(0, 5) == 0) imem[i][6:0] = 7'b1101111;
      end
      imem[32'h40 >> 2] = 32'h0080006F;
      for (int i = 32'h100 >> 2; i < (32'h140 >> 2); i++) imem[i][6:0] = 7'b0010011;
      m_pc = RPC;
      @(posedge clk);
      #1;
      test_reset();
      test_stall();
      test_redirect();
      test_jal();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, meaning fetch-buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port icache_addr  output  32  fetch address to the instruction cache, equal to the current PC.
REQ-006 SHALL have port icache_instr  input  32  instruction returned combinationally for icache_addr in the same cycle.
REQ-007 SHALL have port fetch_valid  output  1  the head buffer entry is valid for decode.
REQ-008 SHALL have port fetch_ready  input  1  decode accepts the head entry this cycle.
REQ-009 SHALL have port fetch_instr  output  32  instruction of the head entry.
REQ-010 SHALL have port fetch_pc  output  32  PC of the head entry.
REQ-011 SHALL have port fetch_pred_taken  output  1  head entry was predicted taken by fetch.
REQ-012 SHALL have port redirect_valid  input  1  flush request from the back end (branch mispredict/exception).
REQ-013 SHALL have port redirect_pc  input  32  new fetch address when redirect_valid is 1.

Function
REQ-014 Buffer: circular FIFO of {pc, instr, pred_taken}, BUF_DEPTH entries, head/tail pointers wrapping modulo BUF_DEPTH, count 0..BUF_DEPTH.
REQ-015 fetch_valid SHALL equal (count != 0); fetch_instr/fetch_pc/fetch_pred_taken SHALL come from the head entry; pop occurs when fetch_valid and fetch_ready.
REQ-016 Push SHALL occur when redirect_valid is 0 and (count < BUF_DEPTH or a pop occurs the same cycle); it writes {PC, icache_instr, pred} at tail.
REQ-017 On push, PC SHALL advance to the next-PC (REQ-020 or REQ-026); otherwise PC SHALL hold.
REQ-018 Simultaneous push and pop at full or empty-with-push SHALL leave count unchanged or +1 respectively, with no data loss; zero-latency bypass from icache to fetch outputs SHALL NOT exist (minimum latency one cycle).
REQ-019 redirect_valid SHALL take priority over push and pop: count cleared, head=tail=0, no push, no pop, PC loaded with {redirect_pc[31:2], 2'b00}.
REQ-020 Sequential next-PC SHALL be PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 icache_addr SHALL always equal PC, including while stalled.

Reset
REQ-022 While rst_n is 0: PC = RESET_PC with bits [1:0] forced to 0, count = 0, pointers = 0, fetch_valid = 0.
REQ-023 Reset asserted mid-operation SHALL discard all buffered entries immediately without waiting for a clock edge.
REQ-024 First push after reset release SHALL occur on the first rising edge with rst_n high, capturing RESET_PC.

Configuration
REQ-025 Macro FETCH_JAL_PREDICT_EN SHALL select static JAL prediction.
REQ-026 With FETCH_JAL_PREDICT_EN defined: if icache_instr[6:0] == 7'b1101111, next-PC SHALL be PC + sign-extended J-immediate {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}, and the pushed pred_taken SHALL be 1; other opcodes use PC + 4 with pred_taken 0.
REQ-027 Without FETCH_JAL_PREDICT_EN: next-PC is always PC + 4 and fetch_pred_taken SHALL be constant 0.

Structure
REQ-028 Shared package SHALL hold RV_OPC_JAL constant, the fetch-entry struct typedef {pc, instr, pred_taken}, and the J-immediate extraction function.
REQ-029 Fetch buffer SHALL be a sub-module fetch_fifo (parameterised depth and entry type with flush input); PC/next-PC logic stays in fetch_unit.

Verification
REQ-030 Reset with RESET_PC=32'h100, fetch_ready=1: icache_addr 0x100, 0x104, 0x108 on successive cycles; fetch_pc 0x100 one cycle after first push.
REQ-031 fetch_ready=0 for 6 cycles, BUF_DEPTH=4: exactly 4 pushes, icache_addr holds 0x110, fetch_pc stays 0x100; release -> entries 0x100..0x10C in order, no loss.
REQ-032 Full buffer, fetch_ready=1 and push same cycle: count stays 4, next fetch_pc 0x104.
REQ-033 redirect_valid with redirect_pc=32'h203 while 3 entries buffered and fetch_ready=1: next cycle fetch_valid=0, icache_addr=0x200; following cycle fetch_pc=0x200.
REQ-034 With FETCH_JAL_PREDICT_EN, instr 32'h0080006F at PC 0x40: next icache_addr 0x48, entry pred_taken=1; without macro next icache_addr 0x44, pred_taken=0.
REQ-035 rst_n pulsed low between clock edges with 2 entries buffered: fetch_valid drops to 0 asynchronously, icache_addr returns to RESET_PC.
